// File: rtl/tartaruga_pkg.sv
// Shared types for the execution slot pipeline: slot record,
// empty-slot constant and the per-slot RAW hazard test.
package tartaruga_pkg;

    // Slot payload storage width; exe_slot_pipe requires PAYLOAD_W <= this.
    localparam int PAYLOAD_MAX_W = 64;

    typedef struct packed {
        logic                     valid;
        logic [4:0]               rd;
        logic                     we;
        logic [PAYLOAD_MAX_W-1:0] payload;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // x0 is hardwired zero, so a write to it never creates a hazard.
    function automatic logic reg_hazard(
        input logic       valid,
        input logic       we,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return valid && we && (rd != 5'd0) &&
               ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/slot_hazard_chk.sv
// RAW hazard comparator array across all execution slots.
// Ports: valid_i/we_i/rd_i per slot, rs1_i/rs2_i operands, hazard_o.
module slot_hazard_chk
    import tartaruga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] we_i,
    input  logic [4:0]       rd_i [DEPTH],
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    output logic             hazard_o
);

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard_o |= reg_hazard(valid_i[i], we_i[i], rd_i[i],
                                   rs1_i, rs2_i);
        end
    end

endmodule

// File: rtl/exe_slot_pipe.sv
// Fixed-latency execution slot pipeline: issue with latency L lands
// in slot DEPTH-L and retires on wb_* exactly L cycles later.
// Ports: clk_i, rstn_i (sync, active-low); issue_* request/ready;
// flush_i; rs1_i/rs2_i -> hazard_o; wb_* completing entry;
// inflight_o valid-slot count; collision_cnt_o rejected issues.
// Macro EXE_SLOT_PIPE_BYPASS_EN: hazard check skips the writeback
// slot q[DEPTH-1], whose result is forwarded that cycle.
module exe_slot_pipe
    import tartaruga_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64,
    parameter int LAT_W     = $clog2(DEPTH+1)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       issue_valid_i,
    input  logic [LAT_W-1:0]           issue_lat_i,
    input  logic [4:0]                 issue_rd_i,
    input  logic                       issue_we_i,
    input  logic [PAYLOAD_W-1:0]       issue_payload_i,
    output logic                       issue_ready_o,
    input  logic                       flush_i,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    output logic                       hazard_o,
    output logic                       wb_valid_o,
    output logic [4:0]                 wb_rd_o,
    output logic                       wb_we_o,
    output logic [PAYLOAD_W-1:0]       wb_payload_o,
    output logic [$clog2(DEPTH+1)-1:0] inflight_o,
    output logic [15:0]                collision_cnt_o
);

    localparam int CNT_W = $clog2(DEPTH+1);

    slot_t       q     [DEPTH];
    slot_t       q_nxt [DEPTH];
    slot_t       new_slot;
    logic [15:0] coll_q;
    int          lat;
    logic        lat_ok;
    logic        slot_free;
    logic        accept;

    always_comb begin
        lat    = int'(issue_lat_i);
        lat_ok = (lat >= 1) && (lat <= DEPTH);
        // Target slot DEPTH-L is fed by q[DEPTH-L-1] on the shift;
        // L=DEPTH targets slot 0, which is always refilled empty.
        slot_free = 1'b1;
        for (int i = 0; i < DEPTH-1; i++) begin
            if (lat == DEPTH-1-i) slot_free = !q[i].valid;
        end
        issue_ready_o = rstn_i && !flush_i && lat_ok && slot_free;
        accept        = issue_valid_i && issue_ready_o;
    end

    always_comb begin
        new_slot         = SLOT_EMPTY;
        new_slot.valid   = 1'b1;
        new_slot.rd      = issue_rd_i;
        new_slot.we      = issue_we_i;
        new_slot.payload = PAYLOAD_MAX_W'(issue_payload_i);
    end

    always_comb begin
        q_nxt[0] = SLOT_EMPTY;
        for (int i = 1; i < DEPTH; i++) q_nxt[i] = q[i-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (lat == DEPTH-i)) q_nxt[i] = new_slot;
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) q_nxt[i] = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= SLOT_EMPTY;
            coll_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
            // Issues dropped by a flush are not collisions.
            if (issue_valid_i && !issue_ready_o && !flush_i &&
                (coll_q != 16'hFFFF)) begin
                coll_q <= coll_q + 16'd1;
            end
        end
    end

    assign collision_cnt_o = coll_q;

    always_comb begin
        inflight_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight_o += CNT_W'(q[i].valid);
        end
    end

    assign wb_valid_o   = q[DEPTH-1].valid;
    assign wb_rd_o      = q[DEPTH-1].rd;
    assign wb_we_o      = q[DEPTH-1].we;
    assign wb_payload_o = q[DEPTH-1].payload[PAYLOAD_W-1:0];

    logic [DEPTH-1:0] hz_valid;
    logic [DEPTH-1:0] hz_we;
    logic [4:0]       hz_rd [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hz_valid[i] = q[i].valid;
            hz_we[i]    = q[i].we;
            hz_rd[i]    = q[i].rd;
        end
`ifdef EXE_SLOT_PIPE_BYPASS_EN
        hz_valid[DEPTH-1] = 1'b0;
`else
        hz_valid[DEPTH-1] = q[DEPTH-1].valid;
`endif
    end

    slot_hazard_chk #(
        .DEPTH (DEPTH)
    ) u_hazard (
        .valid_i  (hz_valid),
        .we_i     (hz_we),
        .rd_i     (hz_rd),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .hazard_o (hazard_o)
    );

endmodule

// File: doc/exe_slot_pipe.md
EXE_SLOT_PIPE -- requirements
Module: exe_slot_pipe

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of execution slots, legal range 2..8.
REQ-002 Parameter PAYLOAD_W, default 64, SHALL set the width of the opaque per-instruction payload.
REQ-003 Parameter LAT_W, default $clog2(DEPTH+1), SHALL set the width of the latency field.
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rstn_i  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 issue_valid_i  in  1  issue request; issue_lat_i  in  LAT_W  latency in cycles.
REQ-007 issue_rd_i  in  5  destination register; issue_we_i  in  1  writes rd; issue_payload_i  in  PAYLOAD_W  carried data.
REQ-008 issue_ready_o  out  1  SHALL indicate the request is accepted this cycle.
REQ-009 flush_i  in  1  SHALL kill all in-flight entries.
REQ-010 rs1_i, rs2_i  in  5 each  SHALL be the operand registers to check for hazards.
REQ-011 hazard_o  out  1  SHALL flag a RAW hazard on rs1_i or rs2_i.
REQ-012 wb_valid_o, wb_rd_o, wb_we_o, wb_payload_o  out  1/5/1/PAYLOAD_W  SHALL be the completing entry.
REQ-013 inflight_o  out  $clog2(DEPTH+1)  SHALL be the count of valid slots.
REQ-014 collision_cnt_o  out  16  SHALL be a saturating count of rejected issue requests.

Function
REQ-015 Slots SHALL be held in q[0..DEPTH-1]; every cycle q[i] <= q[i-1] for i>0 and q[0] <= empty.
REQ-016 An issue accepted in cycle t with latency L SHALL write slot DEPTH-L of the next state and present on wb_* in cycle t+L exactly.
REQ-017 wb_* SHALL be driven combinationally from q[DEPTH-1]; wb_valid_o = q[DEPTH-1].valid.
REQ-018 issue_ready_o SHALL be 1 iff 1<=L<=DEPTH, flush_i=0, and (L=DEPTH or q[DEPTH-L-1].valid=0).
REQ-019 An issue with L=0 or L>DEPTH SHALL be rejected (ready 0) and counted as a collision.
REQ-020 An issue with issue_valid_i=1 and issue_ready_o=0 SHALL leave all slots unchanged apart from the shift, and SHALL increment collision_cnt_o, saturating at 16'hFFFF.
REQ-021 hazard_o SHALL be 1 iff some valid q[i] has we=1, rd!=0 and rd equal to rs1_i or rs2_i.
REQ-022 hazard_o SHALL be 0 whenever the matched register is x0.
REQ-023 flush_i=1 SHALL empty all slots at the next edge; wb_* in the flush cycle remains asserted (committed); an issue in that cycle SHALL be dropped without counting.
REQ-024 inflight_o SHALL equal the popcount of q[*].valid, registered-state based, 0..DEPTH.
REQ-025 Simultaneous wb and an issue with L=1 SHALL be legal: the issued entry appears on wb next cycle.

Reset
REQ-026 When rstn_i=0 at a clock edge: all slots SHALL be invalid, collision_cnt_o=0, and hence wb_valid_o=0, inflight_o=0, hazard_o=0.
REQ-027 Reset mid-operation SHALL discard all in-flight entries with no wb output for them.
REQ-028 issue_ready_o SHALL be 0 while rstn_i=0.

Configuration
REQ-029 Macro EXE_SLOT_PIPE_BYPASS_EN defined: the hazard check SHALL exclude q[DEPTH-1], because the writeback is forwarded that cycle.
REQ-030 Macro EXE_SLOT_PIPE_BYPASS_EN undefined: the hazard check SHALL include every slot, q[DEPTH-1] included.

Structure
REQ-031 The slot struct (valid, rd, we, payload), the empty-slot constant and the reg-hazard function SHALL live in tartaruga_pkg.
REQ-032 The hazard comparator array SHALL be a sub-module named slot_hazard_chk, parametrised by DEPTH.

Verification (DEPTH=4)
REQ-033 Issue L=3 rd=5 at cycle 0 -> wb_valid_o=1, wb_rd_o=5 in cycle 3 only; inflight_o=1 in cycles 1-3.
REQ-034 Issue L=1 at cycle 0, then L=2 at cycle 0+... : issue L=2 at t=0, then L=1 at t=1 -> second rejected (ready 0), collision_cnt_o=1.
REQ-035 Issue L=4 rd=7 we=1, rs1_i=7 -> hazard_o=1 in cycles 1-4 (cycles 1-3 with BYPASS_EN); rd=0 -> hazard_o stays 0.
REQ-036 Three entries in flight, flush_i=1 at t -> inflight_o=0 at t+1, no later wb_valid_o.
REQ-037 rstn_i=0 for one cycle with 2 entries in flight -> all outputs 0 next cycle; issue L=5 -> rejected.
REQ-038 65,540 back-to-back rejected issues -> collision_cnt_o holds 16'hFFFF.
